// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_pkg
//  Description : Shared encodings and defaults for the E-stage HI/LO
//                multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    // MDOp encodings driven by the decoder.
    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // Default busy latencies counted after the Start cycle.
    localparam int C_MULT_CYCLES_DEF = 5;
    localparam int C_DIV_CYCLES_DEF  = 10;

    // Unit control state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

endpackage : mult_div_unit_pkg
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : E-stage multiply/divide unit. Owns HI/LO, runs mult/multu/
//                div/divu with a fixed latency, handles mthi/mtlo, and
//                exposes Busy/Stall to the hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = C_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = C_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    // State and architectural registers.
    md_state_t            r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [63:0]          r_res;       // {hi, lo} waiting to be committed
    logic                 r_res_wr;    // cleared for divide by zero

    // Arithmetic datapath, evaluated on the Start cycle operands.
    logic                 w_div_zero;
    logic                 w_div_ovf;
    logic [31:0]          w_divisor;
    logic [63:0]          w_prod_u;
    logic [63:0]          w_prod_s;
    logic signed [31:0]   w_q_raw;
    logic signed [31:0]   w_r_raw;
    logic [31:0]          w_q_s;
    logic [31:0]          w_r_s;
    logic [31:0]          w_q_u;
    logic [31:0]          w_r_u;
    logic [63:0]          w_res;
    logic                 w_res_wr;
    logic                 w_is_md;
    logic                 w_is_div;

    // A zero divisor is replaced by 1 so the dividers never see it; the
    // result is then suppressed through w_res_wr.
    assign w_div_zero = (SrcB == 32'd0);
    assign w_divisor  = w_div_zero ? 32'd1 : SrcB;

    // INT_MIN / -1 overflows; its architectural answer is pinned explicitly.
    assign w_div_ovf  = (SrcA == 32'h8000_0000) && (SrcB == 32'hFFFF_FFFF);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_prod_u = {32'd0, SrcA} * {32'd0, SrcB};
    assign w_prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};

    // Signed divide kept in isolated assignments so the operators stay signed.
    assign w_q_raw = $signed(SrcA) / $signed(w_divisor);
    assign w_r_raw = $signed(SrcA) % $signed(w_divisor);
    assign w_q_s   = w_div_ovf ? 32'h8000_0000 : w_q_raw;
    assign w_r_s   = w_div_ovf ? 32'd0         : w_r_raw;

    assign w_q_u = SrcA / w_divisor;
    assign w_r_u = SrcA % w_divisor;

    // Select the pending {HI,LO} result and whether it will be committed.
    always_comb begin
        w_res    = 64'd0;
        w_res_wr = 1'b0;
        w_is_md  = 1'b0;
        w_is_div = 1'b0;
        case (MDOp)
            MD_MULT: begin
                w_res    = w_prod_s;
                w_res_wr = 1'b1;
                w_is_md  = 1'b1;
            end
            MD_MULTU: begin
                w_res    = w_prod_u;
                w_res_wr = 1'b1;
                w_is_md  = 1'b1;
            end
            MD_DIV: begin
                w_res    = {w_r_s, w_q_s};
                w_res_wr = ~w_div_zero;
                w_is_md  = 1'b1;
                w_is_div = 1'b1;
            end
            MD_DIVU: begin
                w_res    = {w_r_u, w_q_u};
                w_res_wr = ~w_div_zero;
                w_is_md  = 1'b1;
                w_is_div = 1'b1;
            end
            default: begin
                w_res    = 64'd0;
                w_res_wr = 1'b0;
            end
        endcase
    end

    // Control FSM: latch the result at Start, count down in RUN, commit on exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res    <= 64'd0;
            r_res_wr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        // Start with a non-arithmetic MDOp is dropped.
                        if (w_is_md) begin
                            r_res    <= w_res;
                            r_res_wr <= w_res_wr;
                            r_cnt    <= w_is_div ? c_CNT_W'(DIV_CYCLES)
                                                 : c_CNT_W'(MULT_CYCLES);
                            r_busy   <= 1'b1;
                            r_state  <= ST_RUN;
                        end
                    end else if (MDOp == MD_MTHI) begin
                        r_hi <= SrcA;
                    end else if (MDOp == MD_MTLO) begin
                        r_lo <= SrcA;
                    end
                end
                ST_RUN: begin
                    // Inputs are ignored while running; HI/LO hold old values.
                    if (r_cnt == c_CNT_W'(1)) begin
                        if (r_res_wr) begin
                            r_hi <= r_res[63:32];
                            r_lo <= r_res[31:0];
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy  = r_busy;
    assign Stall = Start | r_busy;
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit: directed scenarios
//                plus randomized traffic against a behavioural HI/LO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: architectural HI/LO plus the one outstanding operation,
    // described by the cycle it was started in and its latency.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    bit          p_wr = 1'b0;
    bit          m_act = 1'b0;
    int          m_start = 0;
    int          m_n = 0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Busy  (Busy),
        .Stall (Stall),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_busy();
        return m_act && (cyc > m_start) && (cyc <= m_start + m_n);
    endfunction

    // Reference arithmetic straight from the instruction definitions.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output bit wr);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        wr = 1'b1;
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            MD_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            MD_MULTU: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            MD_DIV: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    q = sa / sb;
                    r = sa - q * sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    lo = uq[31:0];
                    hi = ur[31:0];
                end
            end
            default: wr = 1'b0;
        endcase
    endtask

    // One clock: check outputs mid-cycle, advance the model across the edge.
    task automatic cycle();
        bit b;
        @(negedge clk);
        b = m_busy();
        chk("busy",  {63'd0, Busy},  {63'd0, b});
        chk("stall", {63'd0, Stall}, {63'd0, (Start | b)});
        chk("hi",    {32'd0, HI},    {32'd0, m_hi});
        chk("lo",    {32'd0, LO},    {32'd0, m_lo});
        if (reset) begin
            m_hi  = 32'd0;
            m_lo  = 32'd0;
            m_act = 1'b0;
        end else if (b) begin
            if (cyc == m_start + m_n) begin
                if (p_wr) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                m_act = 1'b0;
            end
        end else if (Start) begin
            if (MDOp >= MD_MULT && MDOp <= MD_DIVU) begin
                ref_op(MDOp, SrcA, SrcB, p_hi, p_lo, p_wr);
                m_act   = 1'b1;
                m_start = cyc;
                m_n     = (MDOp == MD_MULT || MDOp == MD_MULTU) ? 5 : 10;
            end
        end else if (MDOp == MD_MTHI) begin
            m_hi = SrcA;
        end else if (MDOp == MD_MTLO) begin
            m_lo = SrcA;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
        Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
        cycle();
        Start = 1'b0; MDOp = MD_NONE;
        repeat (n) cycle();
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 9);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = MD_NONE; SrcA = 32'd0; SrcB = 32'd0;
        @(posedge clk); #1;
        cycle();
        reset = 1'b0;
        cycle();

        // Signed and unsigned multiply of -2 by 3.
        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 5);
        chk("mult_hi", {32'd0, HI}, {32'd0, 32'hFFFF_FFFF});
        chk("mult_lo", {32'd0, LO}, {32'd0, 32'hFFFF_FFFA});
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
        chk("multu_hi", {32'd0, HI}, {32'd0, 32'h0000_0002});
        chk("multu_lo", {32'd0, LO}, {32'd0, 32'hFFFF_FFFA});

        // Signed -7/2 and unsigned 7/2.
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        chk("div_lo", {32'd0, LO}, {32'd0, 32'hFFFF_FFFD});
        chk("div_hi", {32'd0, HI}, {32'd0, 32'hFFFF_FFFF});
        run_op(MD_DIVU, 32'd7, 32'd2, 10);
        chk("divu_lo", {32'd0, LO}, 64'd3);
        chk("divu_hi", {32'd0, HI}, 64'd1);

        // mthi / mtlo, then divide by zero leaves them intact.
        MDOp = MD_MTHI; SrcA = 32'h1234_5678; cycle();
        MDOp = MD_MTLO; SrcA = 32'h9ABC_DEF0; cycle();
        MDOp = MD_NONE;
        chk("mthi", {32'd0, HI}, {32'd0, 32'h1234_5678});
        chk("mtlo", {32'd0, LO}, {32'd0, 32'h9ABC_DEF0});
        run_op(MD_DIV, 32'd55, 32'd0, 10);
        chk("dz_hi", {32'd0, HI}, {32'd0, 32'h1234_5678});
        chk("dz_lo", {32'd0, LO}, {32'd0, 32'h9ABC_DEF0});

        // Operand changes and a second Start during Busy are ignored.
        Start = 1'b1; MDOp = MD_MULT; SrcA = 32'd4; SrcB = 32'd5;
        cycle();
        Start = 1'b0; MDOp = MD_NONE; SrcA = 32'd99; SrcB = 32'd77;
        cycle(); cycle();
        Start = 1'b1; MDOp = MD_MULT; SrcA = 32'd7; SrcB = 32'd7;
        cycle();
        Start = 1'b0; MDOp = MD_NONE;
        cycle(); cycle();
        chk("ovl_lo", {32'd0, LO}, 64'd20);
        chk("ovl_hi", {32'd0, HI}, 64'd0);
        chk("ovl_idle", {63'd0, Busy}, 64'd0);

        // Reset in the 4th Busy cycle aborts the divide.
        run_op(MD_DIV, 32'd100, 32'd3, 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_hi", {32'd0, HI}, 64'd0);
        chk("rst_lo", {32'd0, LO}, 64'd0);
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        run_op(MD_MULT, 32'd2, 32'd3, 5);
        chk("post_rst_lo", {32'd0, LO}, 64'd6);

        // Overflowing signed divide.
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        chk("ovf_lo", {32'd0, LO}, {32'd0, 32'h8000_0000});
        chk("ovf_hi", {32'd0, HI}, 64'd0);

        // Randomized traffic; per-cycle checks run against the model.
        for (int i = 0; i < 120; i++) begin
            int kind;
            kind = $urandom_range(0, 19);
            if (kind < 10) begin
                Start = 1'b1; MDOp = 3'($urandom_range(1, 4)); SrcA = rnd32(); SrcB = rnd32();
                cycle();
                Start = 1'b0; MDOp = MD_NONE;
                for (int k = 0; k < 12 && m_busy(); k++) begin
                    SrcA = $urandom; SrcB = $urandom;
                    Start = ($urandom_range(0, 5) == 0);
                    MDOp  = Start ? 3'($urandom_range(1, 4)) : MD_NONE;
                    cycle();
                end
                Start = 1'b0; MDOp = MD_NONE;
            end else if (kind < 14) begin
                MDOp = ($urandom_range(0, 1) != 0) ? MD_MTHI : MD_MTLO;
                SrcA = $urandom;
                cycle();
                MDOp = MD_NONE;
            end else if (kind < 16) begin
                Start = 1'b1; MDOp = 3'($urandom_range(0, 2)); SrcA = $urandom; SrcB = $urandom;
                if (MDOp != MD_NONE) MDOp = MDOp + 3'd4;
                cycle();
                Start = 1'b0; MDOp = MD_NONE;
            end else if (kind < 19) begin
                cycle();
            end else begin
                Start = 1'b1; MDOp = MD_DIVU; SrcA = $urandom; SrcB = $urandom;
                cycle();
                Start = 1'b0; MDOp = MD_NONE;
                repeat ($urandom_range(0, 8)) cycle();
                reset = 1'b1;
                cycle();
                reset = 1'b0;
            end
        end
        repeat (12) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit; sole writer of the HI/LO registers that the E-stage operand select reads (ALUSrc 2 = HI, 3 = LO).
- Executes mult/multu/div/divu with fixed multi-cycle latency, plus mthi/mtlo.
- Raises Busy so the hazard unit stalls later HI/LO-dependent instructions in D.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu after the Start cycle.
- DIV_CYCLES, 10, Busy cycles for div/divu after the Start cycle.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- Start  input  1  one-cycle pulse; E-stage instruction is mult/multu/div/divu
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- SrcA  input  32  forwarded rs value (E stage)
- SrcB  input  32  forwarded rt value (E stage)
- Busy  output  1  operation in flight
- Stall  output  1  Start | Busy, for hazard unit
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- One clock. Reset is synchronous and active-high: clk and reset as named above.
- Reset values: HI=0, LO=0, Busy=0, cycle counter=0, latched result=0, state=IDLE.
- Reset mid-operation aborts the operation. The pending result is discarded, not written.
- States: IDLE and RUN.
- IDLE, Start=1, MDOp in 1..4:
  - compute the result from SrcA/SrcB and latch it internally
  - load the counter with MULT_CYCLES or DIV_CYCLES
  - go to RUN
  - Busy goes high the next cycle.
- RUN: the counter decrements each cycle. Busy=1 while in RUN.
- RUN, counter reaches 1: on that edge, write HI/LO from the latched result, Busy=0, go to IDLE.
- Timing:
  - Start at cycle t, Busy is 1 for cycles t+1..t+N.
  - New HI/LO are visible at cycle t+N+1.
  - HI/LO keep their old values throughout RUN.
- mult: {HI,LO} = signed 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (div or divu): runs the full DIV_CYCLES with Busy, then HI/LO are left unchanged.
- mthi/mtlo (MDOp 5/6, Start=0): write HI or LO from SrcA on the next edge. Single cycle, no Busy.
  - Accepted only in IDLE. The hazard unit guarantees no mthi/mtlo while Stall=1.
- Start while Busy=1 is ignored; the hazard unit never issues it.
- Start with MDOp 0, 5 or 6 is ignored.
- MDOp 5/6 with Start=1 is illegal and ignored.
- Operands are sampled only in the Start cycle. Later changes to SrcA/SrcB do not affect the result.
- Stall is combinational: Start | Busy.

Decomposition:
- Shared package holds:
  - MDOp encodings (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - the state encoding
  - default latency constants
- Single module, no sub-modules. Arithmetic uses native operators, computed once at Start and latched.

Test Plan:
- mult SrcA=0xFFFFFFFE (-2), SrcB=3 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div SrcA=0xFFFFFFF9 (-7), SrcB=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 -> LO=3, HI=1.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 -> HI/LO updated the cycle after each, Busy stays 0.
  - Then divide by zero -> Busy 10 cycles, HI/LO still 0x12345678 / 0x9ABCDEF0.
- Start mult 4*5; change SrcA/SrcB during Busy; assert a second Start in the 3rd Busy cycle -> result LO=20, HI=0, Busy ends at t+5, second Start ignored.
- Start div, assert reset in the 4th Busy cycle -> next cycle HI=LO=0, Busy=0.
  - Fresh mult 2*3 after reset -> LO=6.
- Overflow div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, no X on outputs.
- Stall equals Start | Busy on every cycle of all tests above.
